mips_run_checker: RTL

//   On-chip end-of-run monitor for the single-cycle MIPS core. Watches the instruction bus for program completion
//   (NOP_TIMEOUT consecutive all-zero instructions) or a watchdog expiry. It then scans NUM_WORDS data-memory words

---
 rtl/mips_run_checker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mips_run_checker.sv
// End-of-run monitor for the single-cycle MIPS core. It detects program completion or watchdog expiry,
// then scans data memory against a reference ROM and keeps saturating per-category pass counters.
module mips_run_checker #(
    parameter int DATA_W      = 32,
    parameter int NOP_TIMEOUT = 9,
    parameter int WATCHDOG    = 500,
    parameter int WD_W        = 16,
    parameter int NUM_WORDS   = 22,
    parameter int NUM_CAT     = 6,
    parameter int CAT_W       = 3,
    parameter int CNT_W       = 8,
    localparam int AW         = $clog2(NUM_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [DATA_W-1:0]        inst_i,
    output logic                     mem_rd_en_o,
    output logic [31:0]              mem_addr_o,
    input  logic [DATA_W-1:0]        mem_rd_data_i,
    output logic [AW-1:0]            ref_addr_o,
    input  logic [DATA_W-1:0]        ref_data_i,
    input  logic [CAT_W-1:0]         ref_cat_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timed_out_o,
    output logic [NUM_CAT*CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0]         mismatch_cnt_o
);
    typedef enum logic [2:0] {IDLE, RUN, SCAN, DRAIN, DONE} state_e;

    localparam logic [AW-1:0]    LAST_IDX = AW'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q, state_d;
    logic [WD_W-1:0]  nop_cnt_q, nop_cnt_d, wd_cnt_q, wd_cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             rd_vld_q, rd_vld_d;
    logic             timed_out_q, timed_out_d;
    logic [CNT_W-1:0] pass_q [NUM_CAT];
    logic [CNT_W-1:0] pass_d [NUM_CAT];
    logic [CNT_W-1:0] mismatch_q, mismatch_d;

    logic             start_ok, nop_hit, wd_hit;
    logic [WD_W-1:0]  nop_next, wd_next;

    assign start_ok = start_i && (state_q == IDLE || state_q == DONE);
    assign nop_next = (inst_i == '0) ? nop_cnt_q + WD_W'(1) : '0;
    assign wd_next  = wd_cnt_q + WD_W'(1);
    assign nop_hit  = (nop_next == WD_W'(NOP_TIMEOUT));
    assign wd_hit   = (wd_next == WD_W'(WATCHDOG));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (nop_hit || wd_hit) state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (start_ok) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q == RUN) || (state_q == SCAN) || (state_q == DRAIN);
        done_o      = (state_q == DONE);
        mem_rd_en_o = (state_q == SCAN);
    end

    // Datapath: run counters, scan index and the compare stage that trails each read by one cycle.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        nop_cnt_d   = nop_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        idx_d       = idx_q;
        timed_out_d = timed_out_q;
        mismatch_d  = mismatch_q;
        pass_d      = pass_q;
        rd_vld_d    = (state_q == SCAN);

        if (start_ok) begin
            nop_cnt_d   = '0;
            wd_cnt_d    = '0;
            timed_out_d = 1'b0;
            mismatch_d  = '0;
            for (int k = 0; k < NUM_CAT; k++) pass_d[k] = '0;
        end

        if (state_q == RUN) begin
            nop_cnt_d = nop_next;
            wd_cnt_d  = wd_next;
            if (nop_hit || wd_hit) idx_d = '0;
            if (wd_hit && !nop_hit) timed_out_d = 1'b1;
        end

        if (state_q == SCAN && idx_q != LAST_IDX) idx_d = idx_q + AW'(1);

        if (rd_vld_q && ({1'b0, ref_cat_i} < (CAT_W+1)'(NUM_CAT))) begin
            if (mem_rd_data_i == ref_data_i) begin
                for (int k = 0; k < NUM_CAT; k++) begin
                    if (ref_cat_i == CAT_W'(k) && pass_q[k] != CNT_MAX) pass_d[k] = pass_q[k] + CNT_W'(1);
                end
            end else if (mismatch_q != CNT_MAX) begin
                mismatch_d = mismatch_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nop_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            idx_q       <= '0;
            rd_vld_q    <= 1'b0;
            timed_out_q <= 1'b0;
            mismatch_q  <= '0;
            for (int k = 0; k < NUM_CAT; k++) pass_q[k] <= '0;
        end else begin
            nop_cnt_q   <= nop_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            idx_q       <= idx_d;
            rd_vld_q    <= rd_vld_d;
            timed_out_q <= timed_out_d;
            mismatch_q  <= mismatch_d;
            pass_q      <= pass_d;
        end
    end

    // Address registers hold their last value outside SCAN.
    assign mem_addr_o     = {{(30-AW){1'b0}}, idx_q, 2'b00};
    assign ref_addr_o     = idx_q;
    assign timed_out_o    = timed_out_q;
    assign mismatch_cnt_o = mismatch_q;

    always_comb begin
        pass_cnt_o = '0;
        for (int k = 0; k < NUM_CAT; k++) pass_cnt_o[k*CNT_W +: CNT_W] = pass_q[k];
    end

endmodule
